// File: rtl/hd_pkg.sv
// Shared Hamming(7,4) definitions for the pair encoder and the HD decoder.
// Code word bits [6:0] = {p1,p2,p3,x1,x2,x3,x4}.
package hd_pkg;

  localparam int CW_W   = 7;
  localparam int DATA_W = 4;
  localparam int ERR_W  = 3;
  localparam int PAIR_W = 2 * CW_W;

  localparam int P1_BIT = 6;
  localparam int P2_BIT = 5;
  localparam int P3_BIT = 4;
  localparam int X1_BIT = 3;
  localparam int X2_BIT = 2;
  localparam int X3_BIT = 1;
  localparam int X4_BIT = 0;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } pair_state_e;

  // data = {x1,x2,x3,x4}, x1 in bit 3
  function automatic logic [CW_W-1:0] hamming74_encode(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0] w;
    w         = '0;
    w[X1_BIT] = data[3];
    w[X2_BIT] = data[2];
    w[X3_BIT] = data[1];
    w[X4_BIT] = data[0];
    w[P1_BIT] = data[3] ^ data[2] ^ data[1];
    w[P2_BIT] = data[3] ^ data[2] ^ data[0];
    w[P3_BIT] = data[3] ^ data[1] ^ data[0];
    return w;
  endfunction

  // idx = 0 leaves the word intact; idx = k flips bit k-1
  function automatic logic [CW_W-1:0] inject_err(input logic [CW_W-1:0] word,
                                                 input logic [ERR_W-1:0] idx);
    logic [CW_W-1:0] mask;
    mask = '0;
    if (idx != '0) mask[idx - 3'd1] = 1'b1;
    return word ^ mask;
  endfunction

endpackage

// File: rtl/hd_pair_fifo.sv
// Show-ahead FIFO of DEPTH entries; head is valid whenever empty is low.
module hd_pair_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) return '0;
    return ptr + PTR_W'(1);
  endfunction

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: nothing reads it until an entry is written
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hd_pair_encoder.sv
// Encodes nibbles to Hamming(7,4) with optional single-bit error injection,
// pairs consecutive words and queues the pairs for the HD decoder.
module hd_pair_encoder
  import hd_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ERR_W-1:0]  in_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CW_W-1:0]   code_word1,
  output logic [CW_W-1:0]   code_word2
);

  pair_state_e       r_state;
  pair_state_e       w_state_next;
  logic [CW_W-1:0]   r_half;
  logic [CW_W-1:0]   w_half_next;
  logic [CW_W-1:0]   w_word;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [PAIR_W-1:0] w_head;

  assign w_word     = inject_err(hamming74_encode(in_data), in_err);
  // Registered-only: in EMPTY a nibble is always takeable, even with a full queue
  assign w_in_ready = !((r_state == ST_HALF) && w_full);
  assign w_accept   = in_valid && w_in_ready;
  assign in_ready   = w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_half  <= '0;
    end else begin
      r_state <= w_state_next;
      r_half  <= w_half_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_half_next  = r_half;
    w_push       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_half_next  = w_word;
          w_state_next = ST_HALF;
        end
      end
      ST_HALF: begin
        if (w_accept) begin
          w_push       = 1'b1;
          w_state_next = ST_EMPTY;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  hd_pair_fifo #(
    .DEPTH(DEPTH),
    .W    (PAIR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .push_data({r_half, w_word}),
    .pop      (out_ready),
    .full     (w_full),
    .empty    (w_empty),
    .head     (w_head)
  );

  assign out_valid  = !w_empty;
  assign code_word1 = out_valid ? w_head[PAIR_W-1:CW_W] : '0;
  assign code_word2 = out_valid ? w_head[CW_W-1:0]      : '0;

endmodule

// File: tb/tb_hd_pair_encoder.sv
// Directed bench for hd_pair_encoder (DEPTH=2) against hand-computed code words.
module tb_hd_pair_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [2:0] in_err;
  logic       out_valid;
  logic       out_ready;
  logic [6:0] code_word1;
  logic [6:0] code_word2;

  int n_checks;
  int n_errors;

  // Hand-computed Hamming(7,4) words, index = nibble
  logic [6:0] cw_tab [16];

  hd_pair_encoder #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_err    (in_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .code_word1(code_word1),
    .code_word2(code_word2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Offer one nibble from a negedge; returns at the negedge after it is accepted
  task automatic push_nibble(input logic [3:0] d, input logic [2:0] e);
    bit done;
    done     = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_err   = e;
    for (int c = 0; c < 20 && !done; c++) begin
      if (in_ready) done = 1;
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) check_eq("push_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [6:0] flip(input logic [6:0] w, input logic [2:0] e);
    logic [6:0] r;
    r = w;
    if (e != 3'd0) r[e - 3'd1] = ~r[e - 3'd1];
    return r;
  endfunction

  initial begin
    logic [3:0] d0, d1;
    logic [2:0] e0, e1;

    cw_tab[0]  = 7'h00; cw_tab[1]  = 7'h31; cw_tab[2]  = 7'h52; cw_tab[3]  = 7'h63;
    cw_tab[4]  = 7'h64; cw_tab[5]  = 7'h55; cw_tab[6]  = 7'h36; cw_tab[7]  = 7'h07;
    cw_tab[8]  = 7'h78; cw_tab[9]  = 7'h49; cw_tab[10] = 7'h2A; cw_tab[11] = 7'h1B;
    cw_tab[12] = 7'h1C; cw_tab[13] = 7'h2D; cw_tab[14] = 7'h4E; cw_tab[15] = 7'h7F;

    n_checks  = 0;
    n_errors  = 0;
    in_valid  = 1'b0;
    in_data   = 4'd0;
    in_err    = 3'd0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_cw1", 32'(code_word1), 32'd0);
    check_eq("rst_cw2", 32'(code_word2), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);

    // Plain encoding
    push_nibble(4'b1011, 3'd0);
    check_eq("enc_no_pair_yet", 32'(out_valid), 32'd0);
    push_nibble(4'b0000, 3'd0);
    check_eq("enc_valid", 32'(out_valid), 32'd1);
    check_eq("enc_cw1", 32'(code_word1), 32'h1B);
    check_eq("enc_cw2", 32'(code_word2), 32'h00);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    check_eq("enc_drained", 32'(out_valid), 32'd0);
    check_eq("enc_cw1_zero", 32'(code_word1), 32'd0);

    // Error injection on MSB and LSB
    push_nibble(4'b1011, 3'd7);
    push_nibble(4'b1011, 3'd1);
    check_eq("inj_cw1", 32'(code_word1), 32'h5B);
    check_eq("inj_cw2", 32'(code_word2), 32'h1A);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;

    // Backpressure: fill both queue slots plus the half register
    push_nibble(4'b0001, 3'd0);
    push_nibble(4'b0010, 3'd0);
    push_nibble(4'b0100, 3'd0);
    push_nibble(4'b1000, 3'd0);
    check_eq("bp_ready_empty_full", 32'(in_ready), 32'd1);
    push_nibble(4'b1111, 3'd0);
    check_eq("bp_ready_low", 32'(in_ready), 32'd0);
    check_eq("bp_head_cw1", 32'(code_word1), 32'(cw_tab[1]));
    check_eq("bp_head_cw2", 32'(code_word2), 32'(cw_tab[2]));
    in_valid = 1'b1;
    in_data  = 4'b0110;
    in_err   = 3'd0;
    @(posedge clk); @(negedge clk);
    check_eq("bp_still_blocked", 32'(in_ready), 32'd0);
    check_eq("bp_head_stable", 32'(code_word1), 32'(cw_tab[1]));
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("bp_ready_after_pop", 32'(in_ready), 32'd1);
    check_eq("bp_pair2_cw1", 32'(code_word1), 32'(cw_tab[4]));
    check_eq("bp_pair2_cw2", 32'(code_word2), 32'(cw_tab[8]));
    // Sixth nibble accepted while pair 2 pops: count stays 1
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check_eq("bp_pair3_valid", 32'(out_valid), 32'd1);
    check_eq("bp_pair3_cw1", 32'(code_word1), 32'(cw_tab[15]));
    check_eq("bp_pair3_cw2", 32'(code_word2), 32'(cw_tab[6]));
    @(posedge clk); @(negedge clk);
    check_eq("bp_drained", 32'(out_valid), 32'd0);

    // Streaming with random data and error positions
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) begin
        d0 = 4'($urandom_range(0, 15));
        e0 = 3'($urandom_range(0, 7));
        in_data = d0;
        in_err  = e0;
      end else begin
        d1 = 4'($urandom_range(0, 15));
        e1 = 3'($urandom_range(0, 7));
        in_data = d1;
        in_err  = e1;
      end
      in_valid = 1'b1;
      check_eq($sformatf("str_ready_%0d", i), 32'(in_ready), 32'd1);
      @(posedge clk); @(negedge clk);
      if (i % 2 == 1) begin
        check_eq($sformatf("str_valid_%0d", i / 2), 32'(out_valid), 32'd1);
        check_eq($sformatf("str_cw1_%0d", i / 2), 32'(code_word1), 32'(flip(cw_tab[d0], e0)));
        check_eq($sformatf("str_cw2_%0d", i / 2), 32'(code_word2), 32'(flip(cw_tab[d1], e1)));
      end
    end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("str_drained", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Asynchronous reset while in HALF with two queued pairs
    push_nibble(4'b0001, 3'd0);
    push_nibble(4'b0010, 3'd0);
    push_nibble(4'b0011, 3'd0);
    push_nibble(4'b0100, 3'd0);
    push_nibble(4'b0101, 3'd0);
    check_eq("mid_ready_low", 32'(in_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_cw1", 32'(code_word1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_nibble(4'b1100, 3'd0);
    check_eq("post_rst_half_only", 32'(out_valid), 32'd0);
    push_nibble(4'b1101, 3'd0);
    check_eq("post_rst_cw1", 32'(code_word1), 32'(cw_tab[12]));
    check_eq("post_rst_cw2", 32'(code_word2), 32'(cw_tab[13]));
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check_eq("post_rst_no_stale", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
